// File: rtl/mips_pipe_pkg.sv
// Shared pipeline types for the MIPS-style datapath: ALU opcodes, the ID/EX
// control bundle and the ID/EX interlock state encoding.
package mips_pipe_pkg;

  localparam int ALUOP_W = 4;

  localparam logic [ALUOP_W-1:0] ALU_ADD = 4'd0;
  localparam logic [ALUOP_W-1:0] ALU_SUB = 4'd1;
  localparam logic [ALUOP_W-1:0] ALU_AND = 4'd2;
  localparam logic [ALUOP_W-1:0] ALU_OR  = 4'd3;
  localparam logic [ALUOP_W-1:0] ALU_XOR = 4'd4;
  localparam logic [ALUOP_W-1:0] ALU_NOR = 4'd5;
  localparam logic [ALUOP_W-1:0] ALU_SLT = 4'd6;
  localparam logic [ALUOP_W-1:0] ALU_SLL = 4'd7;
  localparam logic [ALUOP_W-1:0] ALU_SRL = 4'd8;
  localparam logic [ALUOP_W-1:0] ALU_SRA = 4'd9;
  localparam logic [ALUOP_W-1:0] ALU_LUI = 4'd10;

  typedef struct packed {
    logic               regwrite;
    logic               memread;
    logic               memwrite;
    logic               memtoreg;
    logic               alu_src;
    logic [ALUOP_W-1:0] alu_op;
  } ctrl_t;

  localparam ctrl_t BUBBLE_CTRL = '0;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    LDUSE = 2'd1,
    HOLD  = 2'd2
  } state_t;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard compare: the instruction in ID reads the register that the
// load currently in EX has not yet returned.
module load_use_detect #(
  parameter int REG_AW = 5
) (
  input  logic              ex_valid,
  input  logic              ex_memread,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              id_valid,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  output logic              load_use
);

  // NOTE: a continuous assign has no incomplete-branch path, so no latch can be inferred.
  assign load_use = ex_valid & ex_memread & (ex_rd != '0) & id_valid &
                    ((id_uses_rs & (id_rs == ex_rd)) | (id_uses_rt & (id_rt == ex_rd)));

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use interlock, downstream hold and flush.
// Optional saturating stall counter enabled by defining IDEX_STALL_CNT_EN.
import mips_pipe_pkg::*;

module id_ex_stage #(
  parameter int DATA_W      = 32,
  parameter int REG_AW      = 5,
`ifdef IDEX_STALL_CNT_EN
  parameter int STALL_CNT_W = 16,
`endif
  parameter int ALUOP_W     = mips_pipe_pkg::ALUOP_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   id_valid,
  input  logic [REG_AW-1:0]      id_rs,
  input  logic [REG_AW-1:0]      id_rt,
  input  logic [REG_AW-1:0]      id_rd,
  input  logic                   id_uses_rs,
  input  logic                   id_uses_rt,
  input  logic [DATA_W-1:0]      id_rs_data,
  input  logic [DATA_W-1:0]      id_rt_data,
  input  logic [DATA_W-1:0]      id_imm,
  input  logic                   id_regwrite,
  input  logic                   id_memread,
  input  logic                   id_memwrite,
  input  logic                   id_memtoreg,
  input  logic                   id_alu_src,
  input  logic [ALUOP_W-1:0]     id_alu_op,
  input  logic                   flush,
  input  logic                   ex_stall,
  output logic                   ex_valid,
  output logic [REG_AW-1:0]      ex_rs,
  output logic [REG_AW-1:0]      ex_rt,
  output logic [REG_AW-1:0]      ex_rd,
  output logic [DATA_W-1:0]      ex_rs_data,
  output logic [DATA_W-1:0]      ex_rt_data,
  output logic [DATA_W-1:0]      ex_imm,
  output logic                   ex_regwrite,
  output logic                   ex_memread,
  output logic                   ex_memwrite,
  output logic                   ex_memtoreg,
  output logic                   ex_alu_src,
  output logic [ALUOP_W-1:0]     ex_alu_op,
`ifdef IDEX_STALL_CNT_EN
  output logic [STALL_CNT_W-1:0] stall_cycles,
`endif
  output logic                   pc_write_en,
  output logic                   ifid_write_en
);

  ctrl_t  id_ctrl;
  ctrl_t  ex_ctrl;
  state_t state;
  logic   load_use;

  // Masking regwrite here keeps the forwarding unit from ever matching $zero.
  assign id_ctrl = '{regwrite: id_regwrite & id_valid & (id_rd != '0),
                     memread:  id_memread,
                     memwrite: id_memwrite,
                     memtoreg: id_memtoreg,
                     alu_src:  id_alu_src,
                     alu_op:   id_alu_op};

  load_use_detect #(.REG_AW(REG_AW)) u_load_use_detect (
    .ex_valid   (ex_valid),
    .ex_memread (ex_ctrl.memread),
    .ex_rd      (ex_rd),
    .id_valid   (id_valid),
    .id_uses_rs (id_uses_rs),
    .id_uses_rt (id_uses_rt),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .load_use   (load_use)
  );

  // A flush overrides the load-use freeze so the PC can take the branch target.
  assign pc_write_en   = rst_n & ~(ex_stall | (load_use & ~flush));
  assign ifid_write_en = pc_write_en;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid   <= 1'b0;
      ex_rs      <= '0;
      ex_rt      <= '0;
      ex_rd      <= '0;
      ex_rs_data <= '0;
      ex_rt_data <= '0;
      ex_imm     <= '0;
      ex_ctrl    <= BUBBLE_CTRL;
      state      <= RUN;
    end else begin
      if (!ex_stall) begin
        if (flush || load_use) begin
          ex_valid   <= 1'b0;
          ex_rs      <= '0;
          ex_rt      <= '0;
          ex_rd      <= '0;
          ex_rs_data <= '0;
          ex_rt_data <= '0;
          ex_imm     <= '0;
          ex_ctrl    <= BUBBLE_CTRL;
        end else begin
          ex_valid   <= id_valid;
          ex_rs      <= id_rs;
          ex_rt      <= id_rt;
          ex_rd      <= id_rd;
          ex_rs_data <= id_rs_data;
          ex_rt_data <= id_rt_data;
          ex_imm     <= id_imm;
          ex_ctrl    <= id_ctrl;
        end
      end

      case (state)
        RUN: begin
          if (ex_stall)                  state <= HOLD;
          else if (load_use && !flush)   state <= LDUSE;
        end
        LDUSE, HOLD: state <= ex_stall ? HOLD : RUN;
        default:     state <= RUN;
      endcase
    end
  end

  assign ex_regwrite = ex_ctrl.regwrite;
  assign ex_memread  = ex_ctrl.memread;
  assign ex_memwrite = ex_ctrl.memwrite;
  assign ex_memtoreg = ex_ctrl.memtoreg;
  assign ex_alu_src  = ex_ctrl.alu_src;
  assign ex_alu_op   = ex_ctrl.alu_op;

`ifdef IDEX_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
    end else if (load_use && !flush && !ex_stall && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + STALL_CNT_W'(1);
    end
  end
`else
  // No stall counter in this build.
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed vector table, async-reset
// sequences, then randomized traffic against a behavioural pipeline model.
`timescale 1ns/1ps
import mips_pipe_pkg::*;

module tb_id_ex_stage;

  typedef struct packed {
    logic        valid;
    logic [4:0]  rs, rt, rd;
    logic        uses_rs, uses_rt;
    logic [31:0] rs_data, rt_data, imm;
    logic        regwrite, memread, memwrite, memtoreg, alu_src;
    logic [3:0]  alu_op;
  } id_t;

  typedef struct packed {
    logic        valid;
    logic [4:0]  rs, rt, rd;
    logic [31:0] rs_data, rt_data, imm;
    logic        regwrite, memread, memwrite, memtoreg, alu_src;
    logic [3:0]  alu_op;
  } ex_t;

  typedef struct {
    id_t        id;
    bit         flush, stall;
    bit         pcwe, valid;
    logic [4:0] rs, rt, rd;
    bit         regwrite, memread;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid, id_uses_rs, id_uses_rt;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic        id_regwrite, id_memread, id_memwrite, id_memtoreg, id_alu_src;
  logic [3:0]  id_alu_op;
  logic        flush, ex_stall;
  logic        ex_valid;
  logic [4:0]  ex_rs, ex_rt, ex_rd;
  logic [31:0] ex_rs_data, ex_rt_data, ex_imm;
  logic        ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_alu_src;
  logic [3:0]  ex_alu_op;
  logic        pc_write_en, ifid_write_en;
`ifdef IDEX_STALL_CNT_EN
  logic [15:0] stall_cycles;
`endif

  int checks = 0;
  int errors = 0;
  ex_t mex;
  int unsigned mcnt;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .id_memwrite(id_memwrite),
    .id_memtoreg(id_memtoreg), .id_alu_src(id_alu_src), .id_alu_op(id_alu_op),
    .flush(flush), .ex_stall(ex_stall),
    .ex_valid(ex_valid), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
    .ex_memtoreg(ex_memtoreg), .ex_alu_src(ex_alu_src), .ex_alu_op(ex_alu_op),
`ifdef IDEX_STALL_CNT_EN
    .stall_cycles(stall_cycles),
`endif
    .pc_write_en(pc_write_en), .ifid_write_en(ifid_write_en)
  );

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic id_t mk_id(bit v, int rs, int rt, int rd, bit urs, bit urt, bit rw, bit mr);
    id_t r;
    r.valid    = v;
    r.rs       = 5'(rs);
    r.rt       = 5'(rt);
    r.rd       = 5'(rd);
    r.uses_rs  = urs;
    r.uses_rt  = urt;
    r.rs_data  = 32'h1000_0000 | 32'(rs);
    r.rt_data  = 32'h2000_0000 | 32'(rt);
    r.imm      = 32'h0000_0004;
    r.regwrite = rw;
    r.memread  = mr;
    r.memwrite = 1'b0;
    r.memtoreg = mr;
    r.alu_src  = mr;
    r.alu_op   = mr ? ALU_ADD : ALU_OR;
    return r;
  endfunction

  function automatic vec_t mk_vec(id_t id, bit fl, bit st, bit pc, bit vld,
                                  int rs, int rt, int rd, bit rw, bit mr);
    vec_t v;
    v.id = id; v.flush = fl; v.stall = st; v.pcwe = pc; v.valid = vld;
    v.rs = 5'(rs); v.rt = 5'(rt); v.rd = 5'(rd); v.regwrite = rw; v.memread = mr;
    return v;
  endfunction

  task automatic drive(id_t id, bit fl, bit st);
    id_valid = id.valid; id_rs = id.rs; id_rt = id.rt; id_rd = id.rd;
    id_uses_rs = id.uses_rs; id_uses_rt = id.uses_rt;
    id_rs_data = id.rs_data; id_rt_data = id.rt_data; id_imm = id.imm;
    id_regwrite = id.regwrite; id_memread = id.memread; id_memwrite = id.memwrite;
    id_memtoreg = id.memtoreg; id_alu_src = id.alu_src; id_alu_op = id.alu_op;
    flush = fl; ex_stall = st;
  endtask

  task automatic apply_vec(vec_t v, string tag);
    drive(v.id, v.flush, v.stall);
    #1;
    check({tag, " pc_write_en"}, pc_write_en, v.pcwe);
    check({tag, " ifid_write_en"}, ifid_write_en, v.pcwe);
    @(posedge clk); #1;
    check({tag, " ex_valid"}, ex_valid, v.valid);
    check({tag, " ex_rs"}, ex_rs, v.rs);
    check({tag, " ex_rt"}, ex_rt, v.rt);
    check({tag, " ex_rd"}, ex_rd, v.rd);
    check({tag, " ex_regwrite"}, ex_regwrite, v.regwrite);
    check({tag, " ex_memread"}, ex_memread, v.memread);
  endtask

  // Reference model: the instruction held in EX, advanced by the stage's rules.
  function automatic bit model_hazard(ex_t cur, id_t id);
    if (!(cur.valid && cur.memread && cur.rd != 0 && id.valid)) return 1'b0;
    return (id.uses_rs && id.rs == cur.rd) || (id.uses_rt && id.rt == cur.rd);
  endfunction

  function automatic ex_t model_next(ex_t cur, id_t id, bit fl, bit st);
    ex_t n;
    if (st) return cur;
    if (fl || model_hazard(cur, id)) return '0;
    n.valid = id.valid; n.rs = id.rs; n.rt = id.rt; n.rd = id.rd;
    n.rs_data = id.rs_data; n.rt_data = id.rt_data; n.imm = id.imm;
    n.regwrite = id.regwrite && id.valid && (id.rd != 0);
    n.memread = id.memread; n.memwrite = id.memwrite; n.memtoreg = id.memtoreg;
    n.alu_src = id.alu_src; n.alu_op = id.alu_op;
    return n;
  endfunction

  task automatic check_ex(ex_t e);
    check("rnd ex_valid", ex_valid, e.valid);
    check("rnd ex_rs", ex_rs, e.rs);
    check("rnd ex_rt", ex_rt, e.rt);
    check("rnd ex_rd", ex_rd, e.rd);
    check("rnd ex_rs_data", ex_rs_data, e.rs_data);
    check("rnd ex_rt_data", ex_rt_data, e.rt_data);
    check("rnd ex_imm", ex_imm, e.imm);
    check("rnd ex_regwrite", ex_regwrite, e.regwrite);
    check("rnd ex_memread", ex_memread, e.memread);
    check("rnd ex_memwrite", ex_memwrite, e.memwrite);
    check("rnd ex_memtoreg", ex_memtoreg, e.memtoreg);
    check("rnd ex_alu_src", ex_alu_src, e.alu_src);
    check("rnd ex_alu_op", ex_alu_op, e.alu_op);
  endtask

  task automatic release_reset();
    drive('0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  id_t add31, sub4a, lw8, add10, lw0, add0, or11, add20, sub4b, idle;
  vec_t vecs[15];

  initial begin
    add31 = mk_id(1, 1, 2, 3, 1, 1, 1, 0);
    sub4a = mk_id(1, 3, 5, 4, 1, 1, 1, 0);
    lw8   = mk_id(1, 9, 8, 8, 1, 0, 1, 1);
    add10 = mk_id(1, 8, 1, 10, 1, 1, 1, 0);
    lw0   = mk_id(1, 9, 0, 0, 1, 0, 1, 1);
    add0  = mk_id(1, 0, 1, 10, 1, 1, 1, 0);
    or11  = mk_id(1, 12, 13, 11, 1, 1, 1, 0);
    add20 = mk_id(1, 21, 22, 20, 1, 1, 1, 0);
    sub4b = mk_id(1, 20, 5, 4, 1, 1, 1, 0);
    idle  = '0;

    //                 id     fl st pc vld rs  rt  rd  rw mr
    vecs[0]  = mk_vec(add31, 0, 0, 1, 1,  1,  2,  3, 1, 0);
    vecs[1]  = mk_vec(sub4a, 0, 0, 1, 1,  3,  5,  4, 1, 0);
    vecs[2]  = mk_vec(lw8,   0, 0, 1, 1,  9,  8,  8, 1, 1);
    vecs[3]  = mk_vec(add10, 0, 0, 0, 0,  0,  0,  0, 0, 0);
    vecs[4]  = mk_vec(add10, 0, 0, 1, 1,  8,  1, 10, 1, 0);
    vecs[5]  = mk_vec(lw0,   0, 0, 1, 1,  9,  0,  0, 0, 1);
    vecs[6]  = mk_vec(add0,  0, 0, 1, 1,  0,  1, 10, 1, 0);
    vecs[7]  = mk_vec(lw8,   0, 0, 1, 1,  9,  8,  8, 1, 1);
    vecs[8]  = mk_vec(add10, 1, 0, 1, 0,  0,  0,  0, 0, 0);
    vecs[9]  = mk_vec(or11,  0, 0, 1, 1, 12, 13, 11, 1, 0);
    vecs[10] = mk_vec(add20, 0, 0, 1, 1, 21, 22, 20, 1, 0);
    vecs[11] = mk_vec(sub4b, 0, 1, 0, 1, 21, 22, 20, 1, 0);
    vecs[12] = mk_vec(sub4b, 0, 1, 0, 1, 21, 22, 20, 1, 0);
    vecs[13] = mk_vec(sub4b, 0, 1, 0, 1, 21, 22, 20, 1, 0);
    vecs[14] = mk_vec(sub4b, 0, 0, 1, 1, 20,  5,  4, 1, 0);

    // Reset state, with a live instruction presented that must not be captured.
    rst_n = 1'b0;
    drive(add31, 1'b0, 1'b0);
    @(posedge clk); #2;
    check("reset ex_valid", ex_valid, 0);
    check("reset ex_rd", ex_rd, 0);
    check("reset ex_regwrite", ex_regwrite, 0);
    check("reset ex_rs_data", ex_rs_data, 0);
    check("reset pc_write_en", pc_write_en, 0);
    check("reset ifid_write_en", ifid_write_en, 0);
`ifdef IDEX_STALL_CNT_EN
    check("reset stall_cycles", stall_cycles, 0);
`endif
    release_reset();

    for (int i = 0; i < 15; i++) apply_vec(vecs[i], $sformatf("vec%0d", i));
`ifdef IDEX_STALL_CNT_EN
    check("stall_cycles after table", stall_cycles, 1);
`endif

    // Async reset while holding a valid op: clears without a clock edge.
    apply_vec(mk_vec(add20, 0, 0, 1, 1, 21, 22, 20, 1, 0), "hold-pre");
    apply_vec(mk_vec(sub4b, 0, 1, 0, 1, 21, 22, 20, 1, 0), "hold");
    drive(sub4b, 1'b0, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("async-hold ex_valid", ex_valid, 0);
    check("async-hold ex_rd", ex_rd, 0);
    check("async-hold ex_rs_data", ex_rs_data, 0);
    check("async-hold pc_write_en", pc_write_en, 0);
    release_reset();

    // Async reset mid load-use bubble, then verify normal one-bubble behaviour.
    apply_vec(mk_vec(lw8,   0, 0, 1, 1, 9, 8, 8, 1, 1), "lduse-lw");
    apply_vec(mk_vec(add10, 0, 0, 0, 0, 0, 0, 0, 0, 0), "lduse-bubble");
    drive(add10, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("async-lduse ex_valid", ex_valid, 0);
    check("async-lduse ex_memread", ex_memread, 0);
    check("async-lduse pc_write_en", pc_write_en, 0);
    release_reset();
`ifdef IDEX_STALL_CNT_EN
    check("stall_cycles after reset", stall_cycles, 0);
`endif
    apply_vec(mk_vec(lw8,   0, 0, 1, 1, 9, 8,  8, 1, 1), "post-rst-lw");
    apply_vec(mk_vec(add10, 0, 0, 0, 0, 0, 0,  0, 0, 0), "post-rst-bubble");
    apply_vec(mk_vec(add10, 0, 0, 1, 1, 8, 1, 10, 1, 0), "post-rst-add");
`ifdef IDEX_STALL_CNT_EN
    check("stall_cycles after post-rst", stall_cycles, 1);
`endif

    // Randomized traffic against the model; small register range forces hazards.
    rst_n = 1'b0;
    mex = '0;
    mcnt = 0;
    release_reset();
    check_ex(mex);
    for (int i = 0; i < 400; i++) begin
      id_t id;
      bit fl, st, hz, exp_pc;
      id.valid    = ($urandom_range(7) != 0);
      id.rs       = 5'($urandom_range(3));
      id.rt       = 5'($urandom_range(3));
      id.rd       = 5'($urandom_range(3));
      id.uses_rs  = 1'($urandom_range(1));
      id.uses_rt  = 1'($urandom_range(1));
      id.rs_data  = $urandom;
      id.rt_data  = $urandom;
      id.imm      = $urandom;
      id.regwrite = 1'($urandom_range(1));
      id.memread  = ($urandom_range(2) == 0);
      id.memwrite = 1'($urandom_range(1));
      id.memtoreg = 1'($urandom_range(1));
      id.alu_src  = 1'($urandom_range(1));
      id.alu_op   = 4'($urandom_range(15));
      fl = ($urandom_range(7) == 0);
      st = ($urandom_range(4) == 0);
      drive(id, fl, st);
      #1;
      hz = model_hazard(mex, id);
      exp_pc = !(st || (hz && !fl));
      check("rnd pc_write_en", pc_write_en, exp_pc);
      check("rnd ifid_write_en", ifid_write_en, exp_pc);
      if (hz && !fl && !st && mcnt != 32'hFFFF) mcnt++;
      mex = model_next(mex, id, fl, st);
      @(posedge clk); #1;
      check_ex(mex);
`ifdef IDEX_STALL_CNT_EN
      check("rnd stall_cycles", stall_cycles, mcnt);
`endif
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
